// File: rtl/debounce_edge.sv
// Debounce filter for an already-synchronized level: qualifies each new level for
// DEBOUNCE_CYCLES clocks, emits one-cycle edge pulses and counts rejected glitches.
module debounce_edge #(
    parameter int DEBOUNCE_CYCLES = 'd1000,
    parameter int CNT_WIDTH       = 'd16,
    parameter int GLITCH_WIDTH    = 'd8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sync_in,
    input  logic                    glitch_clr,
    output logic                    db_out,
    output logic                    rise_pulse,
    output logic                    fall_pulse,
    output logic [GLITCH_WIDTH-1:0] glitch_cnt
);

    // state     | meaning
    // STABLE_LO | debounced level 0, input agrees
    // CHK_HI    | input went 1, counting consecutive 1 samples
    // STABLE_HI | debounced level 1, input agrees
    // CHK_LO    | input went 0, counting consecutive 0 samples
    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        CHK_HI    = 2'd1,
        STABLE_HI = 2'd2,
        CHK_LO    = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0]    CNT_LAST   = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0]    CNT_ONE    = CNT_WIDTH'(1);
    localparam logic [GLITCH_WIDTH-1:0] GLITCH_MAX = '1;

    state_t                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    db_q, db_d;
    logic                    rise_q, rise_d;
    logic                    fall_q, fall_d;
    logic [GLITCH_WIDTH-1:0] glitch_q, glitch_d;
    logic                    glitch_evt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= STABLE_LO;
            cnt_q    <= '0;
            db_q     <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            glitch_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            db_q     <= db_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            glitch_q <= glitch_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        db_d       = db_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        glitch_evt = 1'b0;
        case (state_q)
            STABLE_LO: begin
                if (sync_in) begin
                    state_d = CHK_HI;
                    cnt_d   = CNT_ONE;
                end
            end
            CHK_HI: begin
                if (!sync_in) begin
                    state_d    = STABLE_LO;
                    glitch_evt = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                    db_d    = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STABLE_HI: begin
                if (!sync_in) begin
                    state_d = CHK_LO;
                    cnt_d   = CNT_ONE;
                end
            end
            CHK_LO: begin
                if (sync_in) begin
                    state_d    = STABLE_HI;
                    glitch_evt = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LO;
                    db_d    = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = STABLE_LO;
        endcase
    end

    // Clear takes priority over a coincident glitch; count saturates at all ones.
    always_comb begin
        glitch_d = glitch_q;
        if (glitch_clr) begin
            glitch_d = '0;
        end else if (glitch_evt && (glitch_q != GLITCH_MAX)) begin
            glitch_d = glitch_q + GLITCH_WIDTH'(1);
        end
    end

    assign db_out     = db_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign glitch_cnt = glitch_q;

endmodule
